dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 256, the data memory size in bytes; the legal address range is 0..MEM_BYTES-1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have ports m0_req / m1_req, input, 1, access request from requester 0 (CPU load/store unit) / requester 1 (DMA/debug).
REQ-005 The block SHALL have ports mX_we, input, 1, 1 = store and 0 = load, for X = 0, 1.
REQ-006 The block SHALL have ports mX_op, input, 3, access type: 0 byte signed, 1 half signed, 2 word, 4 byte unsigned, 5 half unsigned.
REQ-007 The block SHALL have ports mX_addr, input, 32, byte address; and mX_wdata, input, 32, store data (low bytes used).
REQ-008 The block SHALL have ports mX_gnt, output, 1, one-cycle pulse marking the cycle the access is issued.
REQ-009 The block SHALL have ports mX_rvalid, output, 1, mX_rdata, output, 32, and mX_err, output, 1, the response to the access.
REQ-010 The block SHALL have memory-side ports mem_addr (output, 32), mem_op (output, 3), mem_load (output, 1), mem_store (output, 1), mem_wdata (output, 32), and mem_rdata (input, 32, combinational read data).

Function
REQ-011 The FSM SHALL have three states: IDLE, ISSUE and RESP. Transitions: IDLE->ISSUE when any req=1; ISSUE->RESP always; RESP->IDLE always.
REQ-012 In IDLE, when exactly one req=1, that requester SHALL be selected.
REQ-013 In IDLE, when both req=1, the requester not granted most recently SHALL be selected (round-robin). The last-grant register resets to 1, so m0 wins the first tie.
REQ-014 On the IDLE->ISSUE edge, the selected requester's we, op, addr and wdata SHALL be latched into internal registers. Requesters hold req and fields stable until their gnt.
REQ-015 In ISSUE, the selected mX_gnt SHALL be 1 and all other gnt outputs 0.
REQ-016 In ISSUE, mem_addr, mem_op and mem_wdata SHALL equal the latched values.
REQ-017 In ISSUE, mem_load SHALL be 1 for a legal load and mem_store SHALL be 1 for a legal store; both SHALL be 0 in all other states.
REQ-018 mem_store SHALL be gated by !rst, so that no write commits on a reset cycle.
REQ-019 Access size SHALL be 1 for op 0/4, 2 for op 1/5 and 4 for op 2.
REQ-020 An access SHALL be illegal if any of the following holds: op is 3, 6 or 7; it is a store with op 4 or 5; or addr + size > MEM_BYTES (computed at 33 bits, no wrap-around).
REQ-021 For an illegal access, mem_load and mem_store SHALL stay 0, and the response SHALL have err=1 and rdata=0.
REQ-022 At the ISSUE->RESP edge, mem_rdata SHALL be registered for a legal load; rdata SHALL be 0 for stores.
REQ-023 In RESP, the selected mX_rvalid SHALL be 1 for exactly one cycle, with mX_rdata and mX_err valid; outside RESP, rvalid, err and rdata SHALL be 0.
REQ-024 Latency SHALL be: req seen in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2. Maximum throughput is one access per 3 cycles.
REQ-025 A requester that keeps req=1 after rvalid SHALL be treated as issuing a new request; it is re-arbitrated in the next IDLE.
REQ-026 Requests arriving in ISSUE or RESP SHALL wait, with no loss and no queueing beyond the req level.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE, last-grant SHALL be set to 1, and latched fields and rdata registers SHALL be cleared to 0.
REQ-028 After reset, all outputs SHALL be 0.
REQ-029 Reset asserted in ISSUE or RESP SHALL abort the access: no store commits and no rvalid is produced.

Verification
REQ-030 Single store: m0 stores word 0xDEADBEEF to addr 0x10 (op 2). Required: m0_gnt at N+1, mem_store=1 for exactly 1 cycle, m0_rvalid at N+2 with err=0; a subsequent load of 0x10 (op 2) returns 0xDEADBEEF.
REQ-031 Sign handling: byte 0x80 at addr 5. Load op 0 SHALL return 0xFFFFFF80; load op 4 SHALL return 0x00000080.
REQ-032 Contention: m0 and m1 both hold req for 4 accesses. Grants SHALL be m0, m1, m0, m1, and each rvalid SHALL appear only on the granted requester.
REQ-033 Bounds: load word at addr 254 with MEM_BYTES=256 -> mem_load stays 0, rvalid=1, err=1, rdata=0. Also: store op 4 -> err=1 and no write.
REQ-034 Reset mid-access: m1 store to addr 0x20, with rst=1 during ISSUE. Required: mem_store=0 on that cycle, no m1_rvalid, memory at 0x20 unchanged, FSM in IDLE next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave = arbiter view, master = requester/memory-environment view.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [2:0]  m0_op;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [2:0]  m1_op;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [31:0] mem_addr;
  logic [2:0]  mem_op;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_op, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_op, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_op, mem_load, mem_store, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_op, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_op, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_op, mem_load, mem_store, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter: IDLE -> ISSUE -> RESP per access,
// with size/op/bounds legality checking and reset-safe store gating.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [32:0] size;
  logic [32:0] end_addr;
  logic        illegal;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    bus.m0_err    = 1'b0;
    bus.m1_err    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_op    = '0;
    bus.mem_load  = 1'b0;
    bus.mem_store = 1'b0;
    bus.mem_wdata = '0;

    case (op_q)
      3'd0, 3'd4: size = 33'd1;
      3'd1, 3'd5: size = 33'd2;
      3'd2:       size = 33'd4;
      default:    size = 33'd0;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    end_addr = {1'b0, addr_q} + size;
    illegal  = (op_q inside {3'd3, 3'd6, 3'd7}) ||
               (we_q && (op_q inside {3'd4, 3'd5})) ||
               (end_addr > LIMIT);

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = ISSUE;
          sel_d   = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
          last_d  = sel_d;
          if (sel_d) begin
            we_d    = bus.m1_we;
            op_d    = bus.m1_op;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            we_d    = bus.m0_we;
            op_d    = bus.m0_op;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
        end
      end
      ISSUE: begin
        state_d       = RESP;
        err_d         = illegal;
        rdata_d       = (!illegal && !we_q) ? bus.mem_rdata : '0;
        bus.m0_gnt    = !sel_q;
        bus.m1_gnt    = sel_q;
        bus.mem_addr  = addr_q;
        bus.mem_op    = op_q;
        bus.mem_wdata = wdata_q;
        bus.mem_load  = !illegal && !we_q;
        bus.mem_store = !illegal && we_q && !rst;
      end
      RESP: begin
        state_d = IDLE;
        // A reset arriving during the response cycle suppresses it entirely
        if (!rst) begin
          bus.m0_rvalid = !sel_q;
          bus.m1_rvalid = sel_q;
          bus.m0_rdata  = sel_q ? '0 : rdata_q;
          bus.m1_rdata  = sel_q ? rdata_q : '0;
          bus.m0_err    = !sel_q && err_q;
          bus.m1_err    = sel_q && err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory environment plus a transaction-level
// reference model (round-robin rule, legality rules, byte-level memory image).
module tb_dmem_arbiter;
  localparam int unsigned MEM_BYTES = 256;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  env_mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] env_raw;
  int          total = 0;
  int          bad = 0;
  int          rem [2];
  acc_t        cur [2];
  bit          last_g = 1'b1;
  logic [31:0] last_rd;
  logic        last_err;

  function automatic int acc_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] op);
    case (op)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd4:    return {24'h0, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd5:    return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Memory environment: combinational read with extension, byte-lane writes
  always_comb begin
    env_raw = '0;
    for (int k = 0; k < 4; k++)
      env_raw[8*k +: 8] = env_mem[bus.mem_addr[7:0] + 8'(k)];
    bus.mem_rdata = ext(env_raw, bus.mem_op);
  end

  always @(posedge clk) begin
    if (bus.mem_store)
      for (int k = 0; k < 4; k++)
        if (k < acc_size(bus.mem_op))
          env_mem[bus.mem_addr[7:0] + 8'(k)] <= bus.mem_wdata[8*k +: 8];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input acc_t a);
    longint last_byte;
    last_byte = longint'(a.addr) + longint'(acc_size(a.op));
    return (a.op inside {3'd3, 3'd6, 3'd7}) ||
           (a.we && (a.op inside {3'd4, 3'd5})) ||
           (last_byte > longint'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] ref_load(input acc_t a);
    logic [31:0] raw;
    logic [7:0]  b;
    raw = '0;
    for (int k = 0; k < acc_size(a.op); k++) begin
      b = a.addr[7:0] + 8'(k);
      raw[8*k +: 8] = ref_mem[b];
    end
    return ext(raw, a.op);
  endfunction

  function automatic acc_t rand_acc();
    acc_t a;
    a.we    = 1'($urandom % 2);
    a.op    = 3'($urandom % 8);
    case ($urandom % 8)
      0:       a.addr = 32'hFFFF_FFFC + ($urandom % 4);
      1:       a.addr = 32'd250 + ($urandom % 6);
      default: a.addr = $urandom % MEM_BYTES;
    endcase
    a.wdata = $urandom;
    return a;
  endfunction

  task automatic drive();
    bus.m0_req   = (rem[0] != 0);
    bus.m0_we    = cur[0].we;
    bus.m0_op    = cur[0].op;
    bus.m0_addr  = cur[0].addr;
    bus.m0_wdata = cur[0].wdata;
    bus.m1_req   = (rem[1] != 0);
    bus.m1_we    = cur[1].we;
    bus.m1_op    = cur[1].op;
    bus.m1_addr  = cur[1].addr;
    bus.m1_wdata = cur[1].wdata;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                   bus.m0_err, bus.m1_err, bus.mem_load, bus.mem_store}, '0);
    check_eq({tag, "_rd"}, bus.m0_rdata | bus.m1_rdata, '0);
  endtask

  // Serves every pending access; entered at a negedge with requests already driven.
  task automatic serve(input bit rnd);
    int   n;
    int   guard;
    bit   w;
    bit   got;
    bit   ill;
    acc_t a;
    logic [31:0] exp_rd;
    logic [7:0]  b;
    guard = 0;
    while ((rem[0] != 0 || rem[1] != 0) && guard < 64) begin
      guard++;
      w = (rem[0] != 0 && rem[1] != 0) ? ~last_g : (rem[1] != 0);
      n = 0;
      got = 1'b0;
      while (!got && n < 6) begin
        @(negedge clk);
        n++;
        got = bus.m0_gnt | bus.m1_gnt;
      end
      check_eq("gnt_latency", n, 1);
      if (!got) begin
        rem[0] = 0;
        rem[1] = 0;
        drive();
        return;
      end
      a   = cur[w];
      ill = is_illegal(a);
      check_eq("gnt0", bus.m0_gnt, w == 1'b0);
      check_eq("gnt1", bus.m1_gnt, w == 1'b1);
      check_eq("mem_load", bus.mem_load, !ill && !a.we);
      check_eq("mem_store", bus.mem_store, !ill && a.we);
      check_eq("mem_addr", bus.mem_addr, a.addr);
      check_eq("mem_op", bus.mem_op, a.op);
      check_eq("mem_wdata", bus.mem_wdata, a.wdata);
      exp_rd = (!ill && !a.we) ? ref_load(a) : '0;
      if (!ill && a.we)
        for (int k = 0; k < acc_size(a.op); k++) begin
          b = a.addr[7:0] + 8'(k);
          ref_mem[b] = a.wdata[8*k +: 8];
        end
      last_g = w;
      rem[w]--;
      if (rem[w] != 0 && rnd) cur[w] = rand_acc();
      drive();

      @(negedge clk);
      check_eq("rvalid0", bus.m0_rvalid, w == 1'b0);
      check_eq("rvalid1", bus.m1_rvalid, w == 1'b1);
      last_rd  = w ? bus.m1_rdata : bus.m0_rdata;
      last_err = w ? bus.m1_err : bus.m0_err;
      check_eq("rdata", last_rd, exp_rd);
      check_eq("err", last_err, ill);
      check_eq("other_resp", w ? {bus.m0_rdata, bus.m0_err} : {bus.m1_rdata, bus.m1_err}, '0);
      check_eq("resp_no_issue", {bus.m0_gnt, bus.m1_gnt, bus.mem_store, bus.mem_load}, '0);

      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  task automatic one(input bit who, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata);
    cur[who] = '{we: we, op: op, addr: addr, wdata: wdata};
    rem[who] = 1;
    drive();
    serve(1'b0);
  endtask

  initial begin
    int mism;
    for (int i = 0; i < MEM_BYTES; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    rem[0] = 0;
    rem[1] = 0;
    cur[0] = '0;
    cur[1] = '0;
    drive();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_eq("reset_mem_bus", {bus.mem_addr, bus.mem_op, bus.mem_wdata} != '0, 1'b0);
    rst = 1'b0;

    // Single store then load back
    one(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    one(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    check_eq("ld_deadbeef", last_rd, 32'hDEAD_BEEF);

    // Sign/zero extension of byte 0x80
    one(1'b1, 1'b1, 3'd0, 32'd5, 32'h1234_5680);
    one(1'b0, 1'b0, 3'd0, 32'd5, 32'h0);
    check_eq("ld_byte_s", last_rd, 32'hFFFF_FF80);
    one(1'b1, 1'b0, 3'd4, 32'd5, 32'h0);
    check_eq("ld_byte_u", last_rd, 32'h0000_0080);

    // Bounds and op legality
    one(1'b0, 1'b0, 3'd2, 32'd254, 32'h0);
    check_eq("oob_err", {last_err, last_rd}, {1'b1, 32'h0});
    one(1'b0, 1'b0, 3'd2, 32'd252, 32'h0);
    check_eq("top_word_ok", last_err, 1'b0);
    one(1'b1, 1'b0, 3'd4, 32'd255, 32'h0);
    one(1'b1, 1'b0, 3'd5, 32'd255, 32'h0);
    one(1'b0, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'h0);
    one(1'b1, 1'b1, 3'd4, 32'd0, 32'hAAAA_AAAA);
    check_eq("st_op4_err", last_err, 1'b1);
    one(1'b0, 1'b1, 3'd7, 32'd8, 32'h5555_5555);

    // Reset while m1's store is in ISSUE
    cur[1] = '{we: 1'b1, op: 3'd2, addr: 32'h20, wdata: 32'hCAFE_F00D};
    rem[1] = 1;
    drive();
    @(negedge clk);
    check_eq("rst_issue_gnt1", bus.m1_gnt, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_issue_nostore", bus.mem_store, 1'b0);
    rem[1] = 0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
    check_quiet("rst_issue_after");
    for (int k = 0; k < 4; k++)
      check_eq("rst_issue_mem", env_mem[32'h20 + k], ref_mem[32'h20 + k]);
    one(1'b0, 1'b0, 3'd2, 32'h20, 32'h0);

    // Reset while m0's load is in RESP; last-grant must return to 1
    cur[0] = '{we: 1'b0, op: 3'd2, addr: 32'h40, wdata: 32'h0};
    rem[0] = 1;
    drive();
    @(negedge clk);
    check_eq("rst_resp_gnt0", bus.m0_gnt, 1'b1);
    rem[0] = 0;
    drive();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_resp_norvalid", bus.m0_rvalid | bus.m1_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
    check_quiet("rst_resp_after");

    // Contention: both hold req for 4 accesses, grants alternate m0,m1,...
    cur[0] = '{we: 1'b1, op: 3'd2, addr: 32'h80, wdata: 32'h1111_2222};
    cur[1] = '{we: 1'b0, op: 3'd1, addr: 32'h82, wdata: 32'h0};
    rem[0] = 4;
    rem[1] = 4;
    drive();
    serve(1'b0);

    // Randomized rounds
    for (int r = 0; r < 150; r++) begin
      rem[0] = $urandom % 4;
      rem[1] = $urandom % 4;
      if (rem[0] == 0 && rem[1] == 0) rem[$urandom % 2] = 1;
      cur[0] = rand_acc();
      cur[1] = rand_acc();
      drive();
      serve(1'b1);
    end

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (env_mem[i] !== ref_mem[i]) mism++;
    check_eq("mem_image", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
